pulse_stretch: RTL
==================

PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 SHALL have parameter MIN_WIDTH, default 4, minimum cycles level_out is held high per event (legal range 1..255).
REQ-002 SHALL have parameter CNT_W, default 4, width of the pending-event counter (legal range 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port pulse_in  input  1  event pulse; each high cycle is one event.
REQ-006 SHALL have port ack  input  1  consumer acknowledge of the current asserted level.
REQ-007 SHALL have port level_out  output  1  registered level, high while an event is presented.
REQ-008 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-009 SHALL have port pending  output  CNT_W  count of queued events not yet presented.
REQ-010 SHALL have port overflow  output  1  sticky flag, set when an event is lost.

Function
REQ-011 SHALL implement states IDLE, HOLD, WAIT_ACK and GAP; level_out = (state is HOLD or WAIT_ACK), registered.
REQ-012 SHALL, in IDLE with pulse_in=1 at cycle t, enter HOLD so that level_out is high from cycle t+1, with pending unchanged.
REQ-013 SHALL load a hold counter with MIN_WIDTH-1 on HOLD entry and decrement it each HOLD cycle, so HOLD lasts exactly MIN_WIDTH cycles.
REQ-014 SHALL capture ack into a sticky ack_seen bit during HOLD; ack_seen clears on every HOLD entry.
REQ-015 SHALL, on the last HOLD cycle (counter==0), go to GAP if ack_seen or ack is high, otherwise to WAIT_ACK.
REQ-016 SHALL remain in WAIT_ACK until ack=1, then go to GAP on the next edge.
REQ-017 SHALL hold GAP for exactly one cycle with level_out low, guaranteeing a rising edge for every event seen by a downstream edge detector.
REQ-018 SHALL, leaving GAP, enter HOLD if pending>0 or pulse_in=1, else IDLE.
REQ-019 SHALL, on the GAP->HOLD transition, set pending to pending + pulse_in - 1, saturating as in REQ-020.
REQ-020 SHALL, for pulse_in=1 in HOLD or WAIT_ACK, increment pending; if pending already equals 2^CNT_W-1, pending holds and overflow sets.
REQ-021 SHALL hold overflow high once set, until reset.
REQ-022 SHALL ignore ack in IDLE and GAP.
REQ-023 SHALL give minimum back-to-back event period MIN_WIDTH+1 cycles (HOLD plus GAP) when ack is already high.
REQ-024 SHALL, for MIN_WIDTH=1, make HOLD last one cycle and decide GAP/WAIT_ACK in that same cycle.
REQ-025 SHALL drive busy combinationally from state (busy = state != IDLE).

Reset
REQ-026 SHALL, on reset assertion, immediately force state=IDLE, level_out=0, busy=0, pending=0, overflow=0, ack_seen=0, hold counter=0, regardless of clk.
REQ-027 SHALL, on reset assertion mid-event (HOLD, WAIT_ACK or GAP), discard the event and all queued events without completing them.
REQ-028 SHALL ignore pulse_in and ack during any cycle in which reset is high; the first event is accepted on the first rising edge with reset low.

Verification
REQ-029 SHALL verify single event (MIN_WIDTH=4): pulse at t, ack high throughout -> level_out high t+1..t+4, low at t+5, busy low from t+6.
REQ-030 SHALL verify late ack: pulse at t, ack held low until t+9 -> level_out high t+1..t+10, low at t+11.
REQ-031 SHALL verify queueing: 3 pulses at t, t+1, t+2 with ack high -> pending reaches 2; three level_out high windows of 4 cycles, each separated by one low cycle; pending returns to 0.
REQ-032 SHALL verify overflow (CNT_W=2): ack low, 5 pulses while in WAIT_ACK -> pending saturates at 3, overflow=1, and overflow stays 1 after all events drain.
REQ-033 SHALL verify pulse in GAP: with pending=0, a pulse during the GAP cycle -> HOLD entered on the next edge with pending still 0.
REQ-034 SHALL verify asynchronous reset mid-HOLD with pending=2: reset pulse between clock edges -> level_out, pending and busy are 0 immediately, and no further level_out activity occurs.

Source files
------------

// File: rtl/pulse_stretch.sv
// Stretches each input event into a level held high for at least MIN_WIDTH cycles and until it is acknowledged, with a one-cycle low gap between events.
// Events that arrive while one is being presented are queued in a saturating counter; a lost event sets a sticky overflow flag.
module pulse_stretch #(
   parameter int MIN_WIDTH = 4,
   parameter int CNT_W     = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             pulse_in,
   input  logic             ack,
   output logic             level_out,
   output logic             busy,
   output logic [CNT_W-1:0] pending,
   output logic             overflow
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_HOLD,
      S_WAIT_ACK,
      S_GAP
   } state_t;

   localparam logic [7:0]       HOLD_INIT = 8'(MIN_WIDTH - 1);
   localparam logic [CNT_W-1:0] PEND_MAX  = '1;
   localparam logic [CNT_W-1:0] PEND_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_hold_cnt;
   logic [7:0]       w_hold_cnt_nxt;
   logic             r_ack_seen;
   logic             w_ack_seen_nxt;
   logic [CNT_W-1:0] r_pending;
   logic [CNT_W-1:0] w_pending_nxt;
   logic             r_overflow;
   logic             w_overflow_nxt;
   logic             r_level;
   logic             w_level_nxt;

   always_comb begin
      w_state_nxt    = r_state;
      w_hold_cnt_nxt = r_hold_cnt;
      w_ack_seen_nxt = r_ack_seen;
      w_pending_nxt  = r_pending;
      w_overflow_nxt = r_overflow;

      // Events arriving while the level is presented are queued, saturating.
      if ((r_state == S_HOLD || r_state == S_WAIT_ACK) && pulse_in) begin
         if (r_pending == PEND_MAX) begin
            w_overflow_nxt = 1'b1;
         end else begin
            w_pending_nxt = r_pending + PEND_ONE;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (pulse_in) begin
               w_state_nxt    = S_HOLD;
               w_hold_cnt_nxt = HOLD_INIT;
               w_ack_seen_nxt = 1'b0;
            end
         end
         S_HOLD: begin
            w_ack_seen_nxt = r_ack_seen | ack;
            if (r_hold_cnt == 8'd0) begin
               w_state_nxt = (r_ack_seen || ack) ? S_GAP : S_WAIT_ACK;
            end else begin
               w_hold_cnt_nxt = r_hold_cnt - 8'd1;
            end
         end
         S_WAIT_ACK: begin
            if (ack) begin
               w_state_nxt = S_GAP;
            end
         end
         S_GAP: begin
            if (r_pending != '0 || pulse_in) begin
               w_state_nxt    = S_HOLD;
               w_hold_cnt_nxt = HOLD_INIT;
               w_ack_seen_nxt = 1'b0;
               // A pulse arriving in GAP replaces the queued event being consumed.
               if (!pulse_in) begin
                  w_pending_nxt = r_pending - PEND_ONE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_level_nxt = (w_state_nxt == S_HOLD) || (w_state_nxt == S_WAIT_ACK);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_hold_cnt <= 8'd0;
         r_ack_seen <= 1'b0;
         r_pending  <= '0;
         r_overflow <= 1'b0;
         r_level    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_ack_seen <= w_ack_seen_nxt;
         r_pending  <= w_pending_nxt;
         r_overflow <= w_overflow_nxt;
         r_level    <= w_level_nxt;
      end
   end

   assign level_out = r_level;
   assign busy      = (r_state != S_IDLE);
   assign pending   = r_pending;
   assign overflow  = r_overflow;

endmodule
